// File: rtl/dm_bus_pkg.sv
// dm_bus_pkg: shared definitions for the data-memory bus bridge.
//   - FSM state encoding (ST_IDLE, ST_BUS, ST_RESP)
//   - access size codes (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 is reserved)
//   - access_legal(): alignment / size legality check for a core request
package dm_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bytes may sit anywhere, halves need even addresses, words need
  // 4-byte alignment; the reserved size code is never legal.
  function automatic logic access_legal(input logic [1:0] size,
                                        input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational load-data aligner.
// Shifts the addressed byte lane(s) of a bus read word down to bit 0 and
// sign- or zero-extends bytes and halves; words pass straight through.
// Ports:
//   rdata [31:0] in   raw bus read word
//   off   [1:0]  in   byte offset within the word
//   size  [1:0]  in   access size code
//   sign         in   1 = sign-extend, 0 = zero-extend
//   data  [31:0] out  aligned, extended load data
module dm_lane_align
  import dm_bus_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: data = {{24{sign & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dm_bus_bridge.sv
// dm_bus_bridge: multi-cycle bridge from the core load/store path to a
// word-wide memory bus with variable wait states.
// Ports:
//   clk, rst (async, active-low)
//   cpu_req/we/size/sign/addr/wdata  core request, held while cpu_stall=1
//   cpu_rdata, cpu_err               result, valid in the RESP cycle
//   cpu_stall                        combinational hold for the core
//   bus_req/we/be/addr/wdata         registered bus transaction
//   bus_ack, bus_rdata               bus completion and read data
// Parameters: TIMEOUT (BUS cycles without ack before abort, 0 = never),
//             CNT_W (counter width, 2^CNT_W > TIMEOUT).
module dm_bus_bridge
  import dm_bus_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sign,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]  req_off;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] load_data;
  logic        timeout_hit;

  dm_lane_align u_align (
    .rdata (bus_rdata),
    .off   (off_q),
    .size  (size_q),
    .sign  (sign_q),
    .data  (load_data)
  );

  // Byte enables and lane replication for the incoming request, so the
  // addressed bytes land on the right lanes whatever the offset.
  always_comb begin
    req_off = cpu_addr[1:0];
    case (cpu_size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << req_off;
        req_wdata = {4{cpu_wdata[7:0]}};
      end
      SZ_HALF: begin
        req_be    = 4'b0011 << req_off;
        req_wdata = {2{cpu_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = cpu_wdata;
      end
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sign_d  = sign_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;       // error is only ever raised for the RESP cycle
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (access_legal(cpu_size, req_off)) begin
            state_d = ST_BUS;
            we_d    = cpu_we;
            be_d    = req_be;
            addr_d  = {cpu_addr[31:2], 2'b00};
            wdata_d = req_wdata;
            size_d  = cpu_size;
            sign_d  = cpu_sign;
            off_d   = req_off;
            cnt_d   = '0;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ST_BUS: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (bus_ack) begin
          state_d = ST_RESP;
          rdata_d = we_q ? 32'd0 : load_data;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      off_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // bus_req decodes straight from the state flop, so an asynchronous
  // reset mid-transaction drops it without waiting for a clock edge.
  assign bus_req   = (state_q == ST_BUS);
  assign bus_we    = we_q;
  assign bus_be    = be_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign cpu_stall = ((state_q == ST_IDLE) && cpu_req) || (state_q == ST_BUS);

endmodule

// File: tb/tb_dm_bus_bridge.sv
module tb_dm_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sign = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  dm_bus_bridge #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          stall;
    int          buscyc;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bus responder: acks after wait_tgt wait states; optional stray ack
  // while no transaction is on the bus.
  int          wait_tgt  = 0;
  int          wcnt      = 0;
  logic [31:0] rd_val    = '0;
  logic        stray_ack = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus_req) begin
      if (wcnt == wait_tgt) begin
        bus_ack   = 1'b1;
        bus_rdata = rd_val;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        wcnt++;
      end
    end else begin
      bus_ack   = stray_ack;
      bus_rdata = stray_ack ? 32'hFFFF_FFFF : 32'h0;
      wcnt      = 0;
    end
  end

  // Monitor: counts stall and bus cycles, captures bus fields, and scores
  // the response in the cycle where cpu_stall falls.
  int          stall_cnt = 0;
  int          bus_cnt   = 0;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      stall_cnt = 0;
      bus_cnt   = 0;
    end else begin
      if (bus_req) begin
        if (bus_cnt == 0) begin
          cap_be    = bus_be;
          cap_addr  = bus_addr;
          cap_wdata = bus_wdata;
          cap_we    = bus_we;
        end
        bus_cnt++;
      end
      if (cpu_stall) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got rdata=%h err=%b want no response", cpu_rdata, cpu_err);
        end else begin
          mon_e = exp_q.pop_front();
          $display("txn %s: stall=%0d bus=%0d err=%b rdata=%h", mon_e.name, stall_cnt, bus_cnt, cpu_err, cpu_rdata);
          check({mon_e.name, ".rdata"}, cpu_rdata, mon_e.rdata);
          check({mon_e.name, ".err"}, {31'd0, cpu_err}, {31'd0, mon_e.err});
          check({mon_e.name, ".stall"}, stall_cnt, mon_e.stall);
          check({mon_e.name, ".buscyc"}, bus_cnt, mon_e.buscyc);
          if (mon_e.buscyc > 0) begin
            check({mon_e.name, ".be"}, {28'd0, cap_be}, {28'd0, mon_e.be});
            check({mon_e.name, ".addr"}, cap_addr, mon_e.addr);
            check({mon_e.name, ".wdata"}, cap_wdata, mon_e.wdata);
            check({mon_e.name, ".we"}, {31'd0, cap_we}, {31'd0, mon_e.we});
          end
        end
        stall_cnt = 0;
        bus_cnt   = 0;
      end
    end
  end

  task automatic access(string name, bit we, bit [1:0] size, bit sign,
                        bit [31:0] addr, bit [31:0] wdata, bit [31:0] rd,
                        int wt, bit drop,
                        bit [31:0] x_rdata, bit x_err, int x_stall, int x_bus,
                        bit [3:0] x_be, bit [31:0] x_addr, bit [31:0] x_wdata);
    exp_t e;
    int   n;
    bit   done;
    @(posedge clk); #1;
    wait_tgt  = wt;
    rd_val    = rd;
    cpu_we    = we;
    cpu_size  = size;
    cpu_sign  = sign;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    e.name = name; e.rdata = x_rdata; e.err = x_err; e.stall = x_stall;
    e.buscyc = x_bus; e.be = x_be; e.addr = x_addr; e.wdata = x_wdata; e.we = we;
    exp_q.push_back(e);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (drop && bus_req) cpu_req = 1'b0;
      if (!cpu_stall) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s.complete: got still stalled after %0d cycles want completion", name, n);
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.bus_req", {31'd0, bus_req}, 32'd0);
    check("rst.bus_we", {31'd0, bus_we}, 32'd0);
    check("rst.bus_be", {28'd0, bus_be}, 32'd0);
    check("rst.bus_addr", bus_addr, 32'd0);
    check("rst.bus_wdata", bus_wdata, 32'd0);
    check("rst.cpu_rdata", cpu_rdata, 32'd0);
    check("rst.cpu_err", {31'd0, cpu_err}, 32'd0);
    rst = 1'b1;

    //      name          we sz     sg addr          wdata         bus rdata     wt dr  exp rdata    err st bus be       addr          wdata
    access("word_load",   0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 2, 1, 4'b1111, 32'h10, 32'h0);
    access("byte_ld_s",   0, 2'b00, 1, 32'h13, 32'h0,        32'h80112233, 0, 0, 32'hFFFFFF80, 0, 2, 1, 4'b1000, 32'h10, 32'h0);
    access("byte_ld_u",   0, 2'b00, 0, 32'h13, 32'h0,        32'h80112233, 0, 0, 32'h00000080, 0, 2, 1, 4'b1000, 32'h10, 32'h0);
    access("word_misal",  0, 2'b10, 0, 32'h02, 32'h0,        32'h11111111, 0, 0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,  32'h0);
    access("half_store",  1, 2'b01, 0, 32'h06, 32'h0000ABCD, 32'h0,        3, 0, 32'h0,        0, 5, 4, 4'b1100, 32'h04, 32'hABCDABCD);
    access("size_rsvd",   0, 2'b11, 0, 32'h00, 32'h0,        32'h22222222, 0, 0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,  32'h0);
    access("half_ld_s",   0, 2'b01, 1, 32'h02, 32'h0,        32'h80011234, 1, 0, 32'hFFFF8001, 0, 3, 2, 4'b1100, 32'h00, 32'h0);
    access("timeout",     0, 2'b10, 0, 32'h20, 32'h0,        32'h33333333, 99, 0, 32'h0,       1, 5, 4, 4'b1111, 32'h20, 32'h0);
    access("half_ld_u",   0, 2'b01, 0, 32'h00, 32'h0,        32'h1234F00D, 0, 0, 32'h0000F00D, 0, 2, 1, 4'b0011, 32'h00, 32'h0);
    access("byte_st_drop",1, 2'b00, 0, 32'h01, 32'h12345677, 32'h0,        1, 1, 32'h0,        0, 3, 2, 4'b0010, 32'h00, 32'h77777777);
    access("half_misal",  0, 2'b01, 0, 32'h01, 32'h0,        32'h44444444, 0, 0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,  32'h0);

    stray_ack = 1'b1;
    repeat (2) @(posedge clk);
    access("stray_ack",   0, 2'b00, 0, 32'h00, 32'h0,        32'h000000A5, 2, 0, 32'h000000A5, 0, 4, 3, 4'b0001, 32'h00, 32'h0);
    stray_ack = 1'b0;

    // Asynchronous reset in the middle of a bus transaction.
    @(posedge clk); #1;
    wait_tgt  = 99;
    cpu_we    = 1'b0;
    cpu_size  = 2'b10;
    cpu_sign  = 1'b0;
    cpu_addr  = 32'h30;
    cpu_wdata = 32'h0;
    cpu_req   = 1'b1;
    @(posedge clk); #1;
    check("rstmid.bus_req_before", {31'd0, bus_req}, 32'd1);
    #2;
    rst     = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("rstmid.bus_req_async", {31'd0, bus_req}, 32'd0);
    check("rstmid.bus_addr", bus_addr, 32'd0);
    check("rstmid.cpu_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid.idle_bus_req", {31'd0, bus_req}, 32'd0);
    check("rstmid.idle_stall", {31'd0, cpu_stall}, 32'd0);

    access("post_reset",  0, 2'b10, 0, 32'h40, 32'h0,        32'h01234567, 1, 0, 32'h01234567, 0, 3, 2, 4'b1111, 32'h40, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_bus_bridge.md
Name: dm_bus_bridge

Overview:
Multi-cycle data-memory bridge between the processor datapath's load/store path and an external word-wide memory bus with variable wait states. It replaces the single-cycle dm_1k access path.
- Converts byte/half/word requests into word-aligned bus transactions with byte enables.
- Aligns and extends load data.
- Stalls the core until the bus acknowledges.
- Flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, BUS-state cycles without bus_ack before the access is aborted with error; 0 disables the timeout.
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
cpu_req  in  1  access request; held stable by the core while cpu_stall=1.
cpu_we  in  1  1=store, 0=load.
cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
cpu_sign  in  1  load sign-extend (1) / zero-extend (0).
cpu_addr  in  32  byte address.
cpu_wdata  in  32  store data, right-justified.
cpu_rdata  out  32  aligned, extended load data; valid in RESP.
cpu_stall  out  1  core must hold its state and inputs.
cpu_err  out  1  high for exactly the RESP cycle of a failed access.
bus_req  out  1  bus transaction valid.
bus_we  out  1  bus write.
bus_be  out  4  byte enables; lane i = bits[8i+7:8i].
bus_addr  out  32  word address, bits[1:0]=00.
bus_wdata  out  32  lane-replicated store data.
bus_ack  in  1  transaction complete; sampled only in BUS.
bus_rdata  in  32  read data; valid when bus_ack=1.

Behaviour:
- States are IDLE, BUS and RESP. Reset enters IDLE asynchronously.
- Reset values: all bus_* outputs 0, cpu_rdata 0, cpu_err 0, timeout counter 0.
- cpu_stall is combinational: (IDLE & cpu_req) | BUS. It is 0 in RESP.

IDLE state:
- cpu_req=0: remain in IDLE, no bus activity.
- cpu_req=1 and the access is legal: register the address, we, be, wdata, size and sign; go to BUS.
- Legality: word needs addr[1:0]=00; half needs addr[0]=0; size=11 is always illegal.
- cpu_req=1 and the access is illegal: go to RESP with err=1 and rdata=0. No bus transaction is issued.

BUS state:
- bus_req=1; all bus_* outputs are driven from registers.
- bus_ack=1: for a load, capture aligned rdata; go to RESP with err=0. bus_req is 0 in the following cycle.
- No ack: increment the counter. When the counter reaches TIMEOUT-1 and bus_ack=0, go to RESP with err=1 and rdata=0.
- Ack and timeout in the same cycle: ack wins.

RESP state:
- Lasts one cycle; the core consumes the result and advances.
- Then go to IDLE unconditionally. A new cpu_req is sampled in IDLE the next cycle.
- The counter clears on leaving BUS.

Endianness and lanes (little-endian, off = addr[1:0]):
- Byte: be = 0001<<off; wdata = {4{wdata[7:0]}}.
- Half: be = 0011<<off; wdata = {2{wdata[15:0]}}.
- Word: be = 1111; wdata as given.

Loads:
- shifted = bus_rdata >> (8*off).
- Byte and half are extended per cpu_sign; word passes through.
- Stores leave cpu_rdata at 0.

Latency:
- Minimum 3 cycles from request to completion: IDLE with req, BUS with ack, RESP.
- Each bus wait state adds one cycle.

Boundary conditions:
- bus_ack outside BUS is ignored.
- Reset asserted mid-BUS drops bus_req immediately (asynchronously). No retry after reset.
- cpu_req deasserting during BUS does not cancel the transaction.

Decomposition:
- Shared package dm_bus_pkg holds:
  - state encodings ST_IDLE, ST_BUS, ST_RESP;
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - the legality function.
- One combinational sub-module, dm_lane_align, takes rdata, off, size and sign and produces the extended load data.
- Byte-enable and replication logic stays in the top level.

Test Plan:
- Word load, addr 0x0000_0010, bus_ack one cycle after bus_req, bus_rdata 0xDEADBEEF -> bus_be=1111, bus_addr=0x10; stall for 2 cycles; RESP cpu_rdata=0xDEADBEEF, err=0.
- Byte load, signed, addr 0x13, bus_rdata 0x80112233 -> be=1000; cpu_rdata=0xFFFFFF80. Same access unsigned -> 0x00000080.
- Half store, addr 0x06, wdata 0x0000ABCD, ack after 3 wait states -> be=1100, bus_wdata=0xABCDABCD, bus_we=1; stall for 5 cycles total.
- Word load at addr 0x02, and separately size=11 -> bus_req never asserts; RESP the next cycle with err=1 and rdata=0.
- TIMEOUT=4 with no ack -> bus_req high for 4 cycles; RESP with err=1. Ack on the 4th cycle instead -> err=0.
- rst low during BUS -> bus_req drops without waiting for a clock edge; after release, state is IDLE and a fresh load completes normally.
